// File: rtl/axi_rd.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd
// Description : Cache-side AXI3 read master. Performs a full-line INCR refill
//               or a single uncached FIXED beat. Holds the request until the
//               write path is idle. Beats are returned to the cache with zero
//               latency. Optional macro AXI_RD_ERR_EN adds a sticky ret_err
//               output.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd #(
    parameter  int BYTES_PER_LINE = 16,
    localparam int WORDS          = BYTES_PER_LINE / 4,
    localparam int IDX_W          = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    // cache request side
    input  logic             rd_req,
    output logic             rd_rdy,
    input  logic             burst,
    input  logic [31:0]      addr,
    input  logic [1:0]       size,
    input  logic             wr_busy,
    output logic             read_unfinish,
    output logic             ret_valid,
    output logic             ret_last,
    output logic [IDX_W-1:0] ret_idx,
    output logic [31:0]      ret_data,
`ifdef AXI_RD_ERR_EN
    output logic             ret_err,
`endif
    // AXI3 read address channel
    output logic [3:0]       arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic [1:0]       arlock,
    output logic [3:0]       arcache,
    output logic [2:0]       arprot,
    output logic             arvalid,
    input  logic             arready,
    // AXI3 read data channel
    input  logic [3:0]       rid,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_AR   = 2'd2,
        S_R    = 2'd3
    } state_t;

    localparam logic [7:0]       c_line_len = 8'(WORDS - 1);
    localparam logic [IDX_W-1:0] c_idx_max  = IDX_W'(WORDS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_addr;
    logic             r_burst;
    logic [1:0]       r_size;

    logic w_accept;
    logic w_r_hs;
    logic w_unused_ok;

    assign w_accept = rd_req & (r_state == S_IDLE);
    assign w_r_hs   = rvalid & (r_state == S_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (rd_req) r_state <= S_HOLD;
                S_HOLD: if (!wr_busy) r_state <= S_AR;
                S_AR: begin
                    if (arready) begin
                        r_state <= S_R;
                        r_idx   <= '0;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
                        // rlast alone closes the burst, even if short
                        if (rlast) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request fields only change in IDLE, so AR fields stay stable while arvalid=1
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr;
            r_burst <= burst;
            r_size  <= size;
        end
    end

`ifdef AXI_RD_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_err <= 1'b0;
        end else if (w_accept) begin
            ret_err <= 1'b0;
        end else if (w_r_hs && (rresp != 2'b00)) begin
            ret_err <= 1'b1;
        end
    end
    assign w_unused_ok = ^rid;
`else
    assign w_unused_ok = ^{rid, rresp};
`endif

    assign rd_rdy        = (r_state == S_IDLE);
    assign arvalid       = (r_state == S_AR);
    assign rready        = (r_state == S_R);
    assign read_unfinish = (r_state == S_AR) | (r_state == S_R);

    assign arid    = 4'd0;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign araddr  = r_addr;
    assign arlen   = r_burst ? c_line_len : 8'd0;
    assign arsize  = r_burst ? 3'd2 : {1'b0, r_size};
    assign arburst = r_burst ? 2'b01 : 2'b00;

    assign ret_valid = w_r_hs;
    assign ret_last  = rlast & w_r_hs;
    assign ret_data  = rdata;
    assign ret_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd
// Description : Directed bench for axi_rd with a transaction-level reference
//               model compared every cycle, plus hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd;
    localparam int BPL   = 16;
    localparam int WORDS = BPL / 4;
    localparam int IDX_W = $clog2(WORDS);

    logic clk = 1'b0;
    logic reset;
    logic rd_req, rd_rdy, burst, wr_busy, read_unfinish;
    logic [31:0] addr;
    logic [1:0]  size;
    logic ret_valid, ret_last;
    logic [IDX_W-1:0] ret_idx;
    logic [31:0] ret_data;
`ifdef AXI_RD_ERR_EN
    logic ret_err;
`endif
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;
    int seen   = 0;

    axi_rd #(.BYTES_PER_LINE(BPL)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .burst(burst), .addr(addr), .size(size),
        .wr_busy(wr_busy), .read_unfinish(read_unfinish),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_idx(ret_idx), .ret_data(ret_data),
`ifdef AXI_RD_ERR_EN
        .ret_err(ret_err),
`endif
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: open request, write path released, address sent, beats taken
    bit          m_open, m_rel, m_ar, m_err;
    int          m_beats;
    logic [31:0] m_addr;
    logic        m_burst;
    logic [1:0]  m_size;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_open <= 0; m_rel <= 0; m_ar <= 0; m_beats <= 0; m_err <= 0;
        end else if (!m_open) begin
            if (rd_req) begin
                m_open <= 1; m_addr <= addr; m_burst <= burst; m_size <= size; m_err <= 0;
            end
        end else if (!m_rel) begin
            if (!wr_busy) m_rel <= 1;
        end else if (!m_ar) begin
            if (arready) begin m_ar <= 1; m_beats <= 0; end
        end else if (rvalid) begin
            if (rresp != 2'b00) m_err <= 1;
            m_beats <= m_beats + 1;
            if (rlast) begin m_open <= 0; m_rel <= 0; m_ar <= 0; end
        end
    end

    always @(negedge clk) begin
        chk("rd_rdy", rd_rdy, !m_open);
        chk("arvalid", arvalid, m_open && m_rel && !m_ar);
        chk("rready", rready, m_ar);
        chk("read_unfinish", read_unfinish, m_rel);
        chk("ret_valid", ret_valid, rvalid && m_ar);
        chk("ret_last", ret_last, rvalid && rlast && m_ar);
        chk("ar_const", {arid, arlock, arcache, arprot}, 32'd0);
        if (rvalid && m_ar) begin
            chk("ret_idx", ret_idx, m_beats % WORDS);
            chk("ret_data", ret_data, rdata);
        end
        if (m_open && m_rel && !m_ar) begin
            chk("araddr", araddr, m_addr);
            chk("arlen", arlen, m_burst ? WORDS - 1 : 0);
            chk("arsize", arsize, m_burst ? 2 : m_size);
            chk("arburst", arburst, m_burst ? 1 : 0);
        end
`ifdef AXI_RD_ERR_EN
        chk("ret_err", ret_err, m_err);
`endif
        if (ret_valid) seen++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in the first cycle after acceptance
    task automatic start_req(input logic [31:0] a, input logic b, input logic [1:0] s);
        rd_req = 1; addr = a; burst = b; size = s;
        step();
        rd_req = 0; addr = $urandom; burst = $urandom; size = $urandom;
    endtask

    task automatic issue_ar(input int waits, input logic [31:0] exp_addr);
        arready = 0;
        repeat (waits) begin
            chk("araddr_stable", araddr, exp_addr);
            step();
        end
        chk("araddr_stable", araddr, exp_addr);
        arready = 1;
        step();
        arready = 0;
    endtask

    task automatic do_beats(input int n, input bit alt, input int err_beat);
        int b = 0;
        bit on = 1;
        while (b < n) begin
            if (!alt || on) begin
                rvalid = 1; rdata = $urandom; rlast = (b == n - 1);
                rresp = (b == err_beat) ? 2'b10 : 2'b00;
                #1;
                chk("beat_idx", ret_idx, b % WORDS);
                b++;
            end else begin
                rvalid = 0; rlast = 0; rresp = 0;
            end
            on = !on;
            step();
        end
        rvalid = 0; rlast = 0; rresp = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; rd_req = 0; burst = 0; addr = 0; size = 0; wr_busy = 0;
        arready = 0; rid = 4'h5; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        #3;
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_unfinish", read_unfinish, 0);
`ifdef AXI_RD_ERR_EN
        chk("rst_ret_err", ret_err, 0);
`endif
        step();
        reset = 0;
        step();

        // Full-line refill
        start_req(32'h1C00_0040, 1, 2'd2);
        step();
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1C00_0040);
        chk("t1_arlen", arlen, 3);
        chk("t1_arsize", arsize, 2);
        chk("t1_arburst", arburst, 1);
        issue_ar(0, 32'h1C00_0040);
        seen = 0;
        do_beats(4, 0, -1);
        chk("t1_beats", seen, 4);
        chk("t1_idle", rd_rdy, 1);

        // Single uncached word
        start_req(32'hBFAF_8000, 0, 2'd2);
        step();
        chk("t2_arlen", arlen, 0);
        chk("t2_arsize", arsize, 2);
        chk("t2_arburst", arburst, 0);
        issue_ar(0, 32'hBFAF_8000);
        rvalid = 1; rlast = 1; rdata = 32'h1234_5678;
        #1;
        chk("t2_ret_valid", ret_valid, 1);
        chk("t2_ret_last", ret_last, 1);
        chk("t2_ret_idx", ret_idx, 0);
        chk("t2_ret_data", ret_data, 32'h1234_5678);
        step();
        rvalid = 0; rlast = 0;

        // Held behind an outstanding write for 5 cycles
        wr_busy = 1;
        start_req(32'h0000_1003, 0, 2'd0);
        repeat (5) begin
            chk("t3_arvalid_hold", arvalid, 0);
            chk("t3_unfinish_hold", read_unfinish, 0);
            step();
        end
        wr_busy = 0;
        #1;
        chk("t3_arvalid_fall", arvalid, 0);
        step();
        chk("t3_arvalid_rise", arvalid, 1);
        chk("t3_arsize", arsize, 0);
        issue_ar(0, 32'h0000_1003);
        seen = 0;
        do_beats(1, 0, -1);
        chk("t3_beats", seen, 1);

        // Slow address handshake and gapped data
        start_req(32'h2000_0080, 1, 2'd2);
        step();
        issue_ar(3, 32'h2000_0080);
        seen = 0;
        do_beats(4, 1, -1);
        chk("t4_beats", seen, 4);
        chk("t4_idle", rd_rdy, 1);

        // Short burst ended early by rlast
        start_req(32'h3000_0000, 1, 2'd2);
        step();
        issue_ar(0, 32'h3000_0000);
        seen = 0;
        do_beats(2, 0, -1);
        chk("t5_beats", seen, 2);
        chk("t5_idle", rd_rdy, 1);

        // Reset mid-burst after 2 beats
        start_req(32'h4000_0040, 1, 2'd2);
        step();
        issue_ar(0, 32'h4000_0040);
        do_beats(2, 0, -1);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        #1;
        reset = 1;
        #1;
        chk("t6_rd_rdy", rd_rdy, 1);
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_ret_valid", ret_valid, 0);
        chk("t6_unfinish", read_unfinish, 0);
        chk("t6_ret_idx", ret_idx, 0);
        step();
        rvalid = 0;
        reset = 0;
        step();
        start_req(32'h5000_0004, 0, 2'd2);
        chk("t6_new_accept", rd_rdy, 0);
        step();
        issue_ar(0, 32'h5000_0004);
        seen = 0;
        do_beats(1, 0, -1);
        chk("t6_new_beats", seen, 1);

`ifdef AXI_RD_ERR_EN
        // Error response on beat 1 stays visible until the next acceptance
        start_req(32'h6000_0000, 1, 2'd2);
        step();
        issue_ar(0, 32'h6000_0000);
        rvalid = 1; rlast = 0; rresp = 0; step();
        rresp = 2'b10; step();
        chk("t7_err_set", ret_err, 1);
        rresp = 0; step();
        rlast = 1; step();
        rvalid = 0; rlast = 0;
        chk("t7_err_idle", ret_err, 1);
        step();
        chk("t7_err_idle2", ret_err, 1);
        start_req(32'h7000_0000, 0, 2'd2);
        chk("t7_err_clear", ret_err, 0);
        step();
        issue_ar(0, 32'h7000_0000);
        do_beats(1, 0, -1);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_rd.md
AXI_RD -- requirements
Module: axi_rd

Interface
REQ-001 The block SHALL have parameter BYTES_PER_LINE, default 16, giving cache line size in bytes; WORDS = BYTES_PER_LINE/4 and IDX_W = log2(WORDS).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rd_req  in  1  cache read request.
- rd_rdy  out  1  block can accept rd_req.
- burst  in  1  1 = full-line refill, 0 = single uncached beat.
- addr  in  32  request address.
- size  in  2  single-beat size, log2 bytes.
- wr_busy  in  1  write path has an outstanding write.
- read_unfinish  out  1  AR issued or in flight and not yet complete.
- ret_valid  out  1  one beat returned this cycle.
- ret_last  out  1  final beat of the transaction.
- ret_idx  out  IDX_W  beat index within the line.
- ret_data  out  32  beat data.
- ret_err  out  1  present only with AXI_RD_ERR_EN.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI3 read address channel.
- arready  in  1  read address ready.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI3 read data channel.
- rready  out  1  read data ready.

Function
REQ-003 The block SHALL implement states IDLE, HOLD, AR and R.
REQ-004 rd_rdy SHALL equal (state==IDLE); rd_req with rd_rdy=1 SHALL capture addr, burst and size, and the state SHALL move to HOLD; rd_req with rd_rdy=0 SHALL be ignored.
REQ-005 HOLD SHALL move to AR in the first cycle wr_busy=0 and SHALL stay in HOLD while wr_busy=1.
REQ-006 arvalid SHALL equal (state==AR); AR SHALL move to R on arready; all AR fields SHALL remain stable while arvalid=1.
REQ-007 Burst AR fields SHALL be: araddr = captured addr, arlen = WORDS-1, arsize = 3'd2, arburst = INCR (2'b01).
REQ-008 Single AR fields SHALL be: araddr = captured addr, arlen = 0, arsize = {1'b0,size}, arburst = FIXED (2'b00).
REQ-009 arid, arlock, arcache and arprot SHALL be constant 0; rid SHALL be ignored.
REQ-010 rready SHALL equal (state==R); R SHALL move to IDLE on the handshake (rvalid & rready & rlast).
REQ-011 Return outputs SHALL be driven combinationally with zero latency: ret_valid = rvalid & (state==R), ret_data = rdata, ret_last = rlast & ret_valid.
REQ-012 ret_idx SHALL clear to 0 on the AR handshake and SHALL increment by 1, modulo WORDS, after each R handshake.
REQ-013 read_unfinish SHALL equal (state==AR | state==R) and SHALL be 0 in HOLD, so the write path is never deadlocked against a held read.
REQ-014 A new request SHALL be accepted no earlier than the cycle after the final R handshake, because rd_rdy is 0 during that cycle.
REQ-015 rlast arriving before WORDS beats SHALL still end the transaction; ret_idx SHALL NOT gate completion.

Reset
REQ-016 Asserting reset at any time SHALL immediately force state to IDLE and ret_idx to 0, giving arvalid=0, rready=0, ret_valid=0, read_unfinish=0, rd_rdy=1 and ret_err=0.
REQ-017 A transaction interrupted by reset SHALL be abandoned without any return beat.
REQ-018 Captured addr, burst and size registers SHALL need no reset.

Configuration
REQ-019 With macro AXI_RD_ERR_EN defined, ret_err SHALL be a register set on any R handshake with rresp!=2'b00, cleared on request acceptance, and held through the final beat and the following IDLE cycles.
REQ-020 Without AXI_RD_ERR_EN, the ret_err port and its logic SHALL be absent and rresp SHALL be ignored.

Verification
REQ-021 Burst, BYTES_PER_LINE=16, addr=0x1C000040, arready at the first AR cycle -> arlen=3, arsize=2, arburst=1; 4 beats with ret_idx 0..3; ret_last only on idx 3; IDLE the next cycle.
REQ-022 Single, addr=0xBFAF8000, size=2 -> arlen=0, arsize=2, arburst=0; one beat with ret_valid=ret_last=1 and ret_idx=0.
REQ-023 wr_busy=1 for 5 cycles after acceptance -> arvalid=0 and read_unfinish=0 for those 5 cycles; arvalid rises the cycle after wr_busy falls.
REQ-024 arready held low 3 cycles, then rvalid toggling 1,0,1,0 -> araddr stable while arvalid=1; ret_valid only on rvalid cycles; no beat lost.
REQ-025 Reset asserted mid-burst after 2 beats -> outputs take their reset values without waiting for a clock edge; a new request is accepted after reset release.
REQ-026 With AXI_RD_ERR_EN, rresp=2'b10 on beat 1 -> ret_err=1 from the next cycle through the following IDLE; ret_err=0 after the next request is accepted.
